// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve on acceptance.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       div_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [1:0]       ctrl_q, ctrl_nx;
    logic             neg_quo_q, neg_quo_nx;
    logic             neg_rem_q, neg_rem_nx;
    logic [WIDTH-1:0] divisor_q, divisor_nx;
    logic [WIDTH-1:0] rem_q, rem_nx;
    logic [WIDTH-1:0] quo_q, quo_nx;
    logic [WIDTH-1:0] result_q, result_nx;
    logic [CW-1:0]    count_q, count_nx;

    logic             signed_op;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] min_val;
    logic             accept;
    logic [WIDTH:0]   shifted, diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic             last;

    always_comb begin
        signed_op = ~div_ctrl[0];
        sign_a    = signed_op & op_a[WIDTH-1];
        sign_b    = signed_op & op_b[WIDTH-1];
        abs_a     = sign_a ? (-op_a) : op_a;
        abs_b     = sign_b ? (-op_b) : op_b;
        min_val   = {1'b1, {(WIDTH-1){1'b0}}};
        accept    = start & ~flush & (state != CALC);
    end

    // quo_q doubles as the dividend shift register: its MSB feeds the remainder each step.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, divisor_q};
        q_bit    = ~diff[WIDTH];
        rem_step = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], q_bit};
        last     = (count_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_nx   = state;
        ctrl_nx    = ctrl_q;
        neg_quo_nx = neg_quo_q;
        neg_rem_nx = neg_rem_q;
        divisor_nx = divisor_q;
        rem_nx     = rem_q;
        quo_nx     = quo_q;
        result_nx  = result_q;
        count_nx   = count_q;

        unique case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (accept) begin
                    ctrl_nx    = div_ctrl;
                    neg_quo_nx = sign_a ^ sign_b;
                    neg_rem_nx = sign_a;
                    divisor_nx = abs_b;
                    quo_nx     = abs_a;
                    rem_nx     = '0;
                    count_nx   = '0;
                    if (op_b == '0) begin
                        result_nx = div_ctrl[1] ? op_a : '1;
                        state_nx  = DONE;
                    end else if (signed_op && (op_a == min_val) && (op_b == '1)) begin
                        result_nx = div_ctrl[1] ? '0 : op_a;
                        state_nx  = DONE;
                    end else begin
                        state_nx = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_nx = IDLE;
                end else begin
                    rem_nx   = rem_step;
                    quo_nx   = quo_step;
                    count_nx = count_q + CW'(1);
                    if (last) begin
                        state_nx = DONE;
                        unique case (ctrl_q)
                            2'b00:   result_nx = neg_quo_q ? (-quo_step) : quo_step;
                            2'b01:   result_nx = quo_step;
                            2'b10:   result_nx = neg_rem_q ? (-rem_step) : rem_step;
                            default: result_nx = rem_step;
                        endcase
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ctrl_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
            count_q   <= '0;
        end else begin
            state     <= state_nx;
            ctrl_q    <= ctrl_nx;
            neg_quo_q <= neg_quo_nx;
            neg_rem_q <= neg_rem_nx;
            divisor_q <= divisor_nx;
            rem_q     <= rem_nx;
            quo_q     <= quo_nx;
            result_q  <= result_nx;
            count_q   <= count_nx;
        end
    end

    assign busy   = (state == CALC);
    assign done   = (state == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected result/latency,
// a negedge monitor pops and compares whenever done is seen.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  div_ctrl = 2'b00;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    localparam logic [1:0] C_DIV = 2'b00, C_DIVU = 2'b01, C_REM = 2'b10, C_REMU = 2'b11;

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .flush    (flush),
        .div_ctrl (div_ctrl),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          dcyc;
        int          bsy;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   busy_run = 0;
    int   op_id = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_run = 0;
            end else if (done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done with result 0x%08h, required no done", result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("op%0d_result", e.id), result, e.res);
                    check($sformatf("op%0d_done_cycle", e.id), 32'(cyc), 32'(e.dcyc));
                    check($sformatf("op%0d_busy_cycles", e.id), 32'(busy_run), 32'(e.bsy));
                end
                busy_run = 0;
            end else if (busy) begin
                busy_run++;
            end else begin
                busy_run = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller is 1 time unit after a rising edge; start is held for exactly one edge.
    task automatic issue_raw(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        div_ctrl = c;
        op_a     = a;
        op_b     = b;
        step();
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        div_ctrl = 2'($urandom_range(0, 3));
    endtask

    task automatic op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_res, input bit special);
        exp_t e;
        e.res  = exp_res;
        e.dcyc = cyc + (special ? 1 : 33);
        e.bsy  = special ? 0 : 32;
        e.id   = op_id++;
        sb.push_back(e);
        issue_raw(c, a, b);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        check("done_within_bound", {31'b0, done}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required normal end");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        step();

        // Normal signed/unsigned operations
        op(C_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0); wait_done(); step();
        op(C_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0); wait_done(); step();
        op(C_REMU, 32'd7, 32'd2, 32'd1, 1'b0);               wait_done(); step();
        op(C_DIVU, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 1'b0); wait_done(); step();
        op(C_DIV,  32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0); wait_done(); step();
        op(C_REM,  32'd100, 32'hFFFFFFF9, 32'd2, 1'b0);      wait_done(); step();
        op(C_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0); wait_done(); step();
        op(C_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0); wait_done(); step();

        // Divide by zero and signed overflow
        op(C_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1);        wait_done(); step();
        op(C_REM,  32'd5, 32'd0, 32'd5, 1'b1);               wait_done(); step();
        op(C_DIV,  32'd5, 32'd0, 32'hFFFFFFFF, 1'b1);        wait_done(); step();
        op(C_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1); wait_done(); step();
        op(C_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1); wait_done(); step();

        // start held high through CALC with changing operands
        begin
            exp_t e;
            e.res = 32'd6; e.dcyc = cyc + 33; e.bsy = 32; e.id = op_id++;
            sb.push_back(e);
            start = 1'b1; div_ctrl = C_DIV; op_a = 32'd20; op_b = 32'd3;
            repeat (20) begin
                step();
                op_a = $urandom;
                op_b = $urandom | 32'd1;
                div_ctrl = C_REMU;
            end
            start = 1'b0;
            wait_done(); step();
        end

        // Back-to-back: next start accepted in the DONE cycle
        op(C_DIVU, 32'd1000, 32'd10, 32'd100, 1'b0); wait_done();
        op(C_REMU, 32'd1000, 32'd7, 32'd6, 1'b0);    wait_done(); step();

        // Flush mid-CALC: no done, result kept
        issue_raw(C_DIV, 32'd50, 32'd5);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_result_kept", result, 32'd6);
        repeat (40) step();
        check("flush_result_still_kept", result, 32'd6);

        // Flush in IDLE blocks start
        start = 1'b1; flush = 1'b1; div_ctrl = C_DIVU; op_a = 32'd9; op_b = 32'd0;
        step();
        start = 1'b0; flush = 1'b0;
        check("flush_idle_busy", {31'b0, busy}, 32'd0);
        check("flush_idle_done", {31'b0, done}, 32'd0);
        step();

        // Reset mid-CALC
        issue_raw(C_DIVU, 32'd12345, 32'd11);
        repeat (15) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_result", result, 32'd0);
        step();
        op(C_DIV, 32'd1000, 32'hFFFFFFFD, 32'hFFFFFEB3, 1'b0); wait_done(); step();

        repeat (5) step();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
